// File: rtl/garb8way16_rr_pkg.sv
// Shared constants and state encoding for the 8-way round-robin word arbiter.
package garb8way16_rr_pkg;

  localparam int WAYS  = 8;
  localparam int SEL_W = 3;

  // Pointer value after reset: the search starts at ptr+1, so source 0 wins first.
  localparam logic [SEL_W-1:0] PTR_RST = 3'd7;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/garb8way16_rr_pick8.sv
// Round-robin picker: first requester strictly after ptr, wrapping 7->0.
module rr_pick8
  import garb8way16_rr_pkg::*;
(
  input  logic [WAYS-1:0]  v,
  input  logic [SEL_W-1:0] ptr,
  output logic [WAYS-1:0]  grant,
  output logic [SEL_W-1:0] g,
  output logic             any
);

  // Scan offsets 1..8 from ptr; offset 8 wraps back to ptr itself, so the
  // last granted source is only picked again when nobody else is asking.
  always_comb begin
    logic [SEL_W-1:0] idx;
    grant = '0;
    g     = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = 1; k <= WAYS; k++) begin
      idx = ptr + SEL_W'(k);
      if (!any && v[idx]) begin
        any        = 1'b1;
        g          = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/garb8way16_rr.sv
// 8-source round-robin arbiter into a single registered output slot.
module garb8way16_rr
  import garb8way16_rr_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic [WIDTH-1:0] d5,
  input  logic [WIDTH-1:0] d6,
  input  logic [WIDTH-1:0] d7,
  input  logic [WAYS-1:0]  v,
  output logic [WAYS-1:0]  rdy,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [SEL_W-1:0] y_sel
);

  state_t           state;
  state_t           state_nxt;
  logic [SEL_W-1:0] ptr;
  logic [WAYS-1:0]  grant;
  logic [SEL_W-1:0] g;
  logic             any;
  logic             load;
  logic             take;
  logic [WIDTH-1:0] d_sel;

  rr_pick8 u_pick (
    .v     (v),
    .ptr   (ptr),
    .grant (grant),
    .g     (g),
    .any   (any)
  );

  // The slot can be (re)filled when empty or when its word leaves this edge;
  // reset blocks acceptance so no source believes its word was taken.
  assign load = (state == ST_EMPTY) || y_ready;
  assign take = !reset && load && any;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_nxt;
  end

  // Next state: only a load edge changes occupancy.
  always_comb begin
    state_nxt = state;
    if (load) state_nxt = any ? ST_FULL : ST_EMPTY;
  end

  // Outputs decoded from state and the current grant.
  always_comb begin
    rdy     = take ? grant : '0;
    y_valid = (state == ST_FULL);
  end

  // 8-way data select steered by the picker index.
  always_comb begin
    d_sel = d0;
    unique case (g)
      3'd0: d_sel = d0;
      3'd1: d_sel = d1;
      3'd2: d_sel = d2;
      3'd3: d_sel = d3;
      3'd4: d_sel = d4;
      3'd5: d_sel = d5;
      3'd6: d_sel = d6;
      3'd7: d_sel = d7;
    endcase
  end

  // Output word, source index and round-robin pointer update on a grant only.
  always_ff @(posedge clk) begin
    if (reset) begin
      y     <= '0;
      y_sel <= '0;
      ptr   <= PTR_RST;
    end else if (take) begin
      y     <= d_sel;
      y_sel <= g;
      ptr   <= g;
    end
  end

endmodule
